rgb_stream_packer: RTL and testbench

- Sits directly upstream of the AXI4-Stream video output port and packs the pixel generator's per-pixel 24-bit RGB stream into 32-bit stream words, at 4 pixels per 3 words.
- Keeps its own line and frame counters.
- Generates tuser (start of frame) on the first word of each frame and tlast (end of line) on the last word of each line.
- Decouples upstream pixel flow from downstream backpressure with a single registered output stage.

---
 rtl/rgb_stream_packer.sv | 174 +++++++++++++++++
 tb/tb_rgb_stream_packer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_stream_packer.sv
// Packs a 24-bit RGB pixel stream into 32-bit AXI4-Stream words (4 pixels -> 3 words).
// Optional macro PACKER_SOF_RESYNC_EN adds in_sof / sof_err frame resynchronisation.
module rgb_stream_packer #(
    parameter int X_PIXELS = 640,
    parameter int Y_SIZE   = 480,
    parameter int XW       = 10,
    parameter int YW       = 9
) (
    input  logic        out_stream_aclk,
    input  logic        periph_resetn,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tlast,
    output logic        out_stream_tuser,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready,
`ifdef PACKER_SOF_RESYNC_EN
    input  logic        in_sof,
    output logic        sof_err,
`endif
    output logic        frame_done
);

    typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;

    localparam logic [XW-1:0] X_LAST = XW'(X_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    phase_t        phase_reg, phase_next, cur_phase;
    logic [XW-1:0] x_reg, x_next, cur_x;
    logic [YW-1:0] y_reg, y_next, cur_y;
    logic [23:0]   hold_reg, hold_next;
    logic [31:0]   tdata_reg, tdata_next;
    logic          tvalid_reg, tvalid_next;
    logic          tlast_reg, tlast_next;
    logic          tuser_reg, tuser_next;
    // Marks the held word as the final word of a frame, so frame_done can follow its handshake
    logic          eof_reg, eof_next;
    logic          frame_done_reg, frame_done_next;
    logic          accept, out_fire, resync;

    assign in_ready = !tvalid_reg || out_stream_tready;
    assign accept   = in_valid && in_ready;
    assign out_fire = tvalid_reg && out_stream_tready;

`ifdef PACKER_SOF_RESYNC_EN
    logic sof_err_reg;
    assign resync  = accept && in_sof && ((x_reg != '0) || (y_reg != '0) || (phase_reg != P0));
    assign sof_err = sof_err_reg;

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            sof_err_reg <= 1'b0;
        end else if (resync) begin
            sof_err_reg <= 1'b1;
        end
    end
`else
    assign resync = 1'b0;
`endif

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            phase_reg <= P0;
        end else begin
            phase_reg <= phase_next;
        end
    end

    always_comb begin
        phase_next      = phase_reg;
        x_next          = x_reg;
        y_next          = y_reg;
        hold_next       = hold_reg;
        tdata_next      = tdata_reg;
        tvalid_next     = tvalid_reg;
        tlast_next      = tlast_reg;
        tuser_next      = tuser_reg;
        eof_next        = eof_reg;
        frame_done_next = out_fire && tlast_reg && eof_reg;

        // A resynchronising pixel is handled as pixel 0 of a fresh frame
        cur_phase = resync ? P0 : phase_reg;
        cur_x     = resync ? '0 : x_reg;
        cur_y     = resync ? '0 : y_reg;

        if (out_fire) begin
            tvalid_next = 1'b0;
        end

        if (accept) begin
            if (cur_x == X_LAST) begin
                x_next = '0;
                y_next = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
            end else begin
                x_next = cur_x + XW'(1);
                y_next = cur_y;
            end

            case (cur_phase)
                P0: begin
                    hold_next  = {in_b, in_g, in_r};
                    phase_next = P1;
                end
                P1: begin
                    tdata_next  = {in_r, hold_reg[23:0]};
                    hold_next   = {8'h00, in_b, in_g};
                    // Groups are 4-aligned within a line, so x=1 here means the group began at x=0
                    tuser_next  = (cur_x == XW'(1)) && (cur_y == '0);
                    tlast_next  = 1'b0;
                    eof_next    = 1'b0;
                    tvalid_next = 1'b1;
                    phase_next  = P2;
                end
                P2: begin
                    tdata_next  = {in_g, in_r, hold_reg[15:0]};
                    hold_next   = {16'h0000, in_b};
                    tuser_next  = 1'b0;
                    tlast_next  = 1'b0;
                    eof_next    = 1'b0;
                    tvalid_next = 1'b1;
                    phase_next  = P3;
                end
                P3: begin
                    tdata_next  = {in_b, in_g, in_r, hold_reg[7:0]};
                    hold_next   = '0;
                    tuser_next  = 1'b0;
                    tlast_next  = (cur_x == X_LAST);
                    eof_next    = (cur_x == X_LAST) && (cur_y == Y_LAST);
                    tvalid_next = 1'b1;
                    phase_next  = P0;
                end
                default: phase_next = P0;
            endcase
        end
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            x_reg          <= '0;
            y_reg          <= '0;
            hold_reg       <= '0;
            tdata_reg      <= '0;
            tvalid_reg     <= 1'b0;
            tlast_reg      <= 1'b0;
            tuser_reg      <= 1'b0;
            eof_reg        <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            x_reg          <= x_next;
            y_reg          <= y_next;
            hold_reg       <= hold_next;
            tdata_reg      <= tdata_next;
            tvalid_reg     <= tvalid_next;
            tlast_reg      <= tlast_next;
            tuser_reg      <= tuser_next;
            eof_reg        <= eof_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign out_stream_tdata  = tdata_reg;
    assign out_stream_tkeep  = 4'hF;
    assign out_stream_tlast  = tlast_reg;
    assign out_stream_tuser  = tuser_reg;
    assign out_stream_tvalid = tvalid_reg;
    assign frame_done        = frame_done_reg;

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Self-checking bench for rgb_stream_packer: byte-queue reference packer plus literal spot checks.
module tb_rgb_stream_packer;

    localparam int XP  = 16;
    localparam int YS  = 4;
    localparam int WPL = XP * 3 / 4;
    localparam int FW  = WPL * YS;

    typedef struct {
        logic [31:0] d;
        logic        last;
        logic        user;
        logic        eof;
    } word_t;

    logic        clk;
    logic        periph_resetn;
    logic [7:0]  in_r, in_g, in_b;
    logic        in_valid, in_ready;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast, tuser, tvalid, tready;
    logic        frame_done;
`ifdef PACKER_SOF_RESYNC_EN
    logic        in_sof, sof_err;
`endif

    rgb_stream_packer #(.X_PIXELS(XP), .Y_SIZE(YS), .XW(10), .YW(9)) dut (
        .out_stream_aclk   (clk),
        .periph_resetn     (periph_resetn),
        .in_r              (in_r),
        .in_g              (in_g),
        .in_b              (in_b),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .out_stream_tdata  (tdata),
        .out_stream_tkeep  (tkeep),
        .out_stream_tlast  (tlast),
        .out_stream_tuser  (tuser),
        .out_stream_tvalid (tvalid),
        .out_stream_tready (tready),
`ifdef PACKER_SOF_RESYNC_EN
        .in_sof            (in_sof),
        .sof_err           (sof_err),
`endif
        .frame_done        (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nfail = 0;
    int acc_cnt = 0;
    int n_fd = 0;

    // Reference model state
    word_t       exp_q[$];
    word_t       seen[$];
    logic [7:0]  bq[$];
    int          frame_pix = 0;
    int          frame_word = 0;
    logic        fd_exp = 1'b0;
    logic        fd_next;
    logic        sof_err_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        exp_q.delete();
        bq.delete();
        frame_pix   = 0;
        frame_word  = 0;
        sof_err_exp = 1'b0;
    endfunction

    function automatic void model_push(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                       input logic sof);
        word_t w;
        if (sof && frame_pix != 0) begin
            bq.delete();
            frame_pix   = 0;
            frame_word  = 0;
            sof_err_exp = 1'b1;
        end
        bq.push_back(r);
        bq.push_back(g);
        bq.push_back(b);
        frame_pix = (frame_pix + 1) % (XP * YS);
        while (bq.size() >= 4) begin
            w.d    = {bq[3], bq[2], bq[1], bq[0]};
            w.user = (frame_word == 0);
            w.last = ((frame_word % WPL) == WPL - 1);
            w.eof  = (frame_word == FW - 1);
            for (int i = 0; i < 4; i++) void'(bq.pop_front());
            frame_word = (frame_word + 1) % FW;
            exp_q.push_back(w);
        end
    endfunction

    // Compare process: every cycle, outputs against the model; then advance the model
    always @(negedge clk) begin
        if (!periph_resetn) begin
            check("rst_tvalid", 32'(tvalid), 32'd0);
            check("rst_tdata", tdata, 32'd0);
            check("rst_tlast_tuser", 32'({tlast, tuser}), 32'd0);
            check("rst_frame_done", 32'(frame_done), 32'd0);
`ifdef PACKER_SOF_RESYNC_EN
            check("rst_sof_err", 32'(sof_err), 32'd0);
`endif
            model_clear();
            fd_exp = 1'b0;
        end else begin
            check("frame_done", 32'(frame_done), 32'(fd_exp));
            check("in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || tready));
            check("tvalid", 32'(tvalid), 32'(exp_q.size() != 0));
            check("tkeep", 32'(tkeep), 32'hF);
            if (tvalid && exp_q.size() > 0) begin
                check("tdata", tdata, exp_q[0].d);
                check("tlast", 32'(tlast), 32'(exp_q[0].last));
                check("tuser", 32'(tuser), 32'(exp_q[0].user));
            end
`ifdef PACKER_SOF_RESYNC_EN
            check("sof_err", 32'(sof_err), 32'(sof_err_exp));
`endif
            fd_next = 1'b0;
            if (tvalid && tready) begin
                seen.push_back('{tdata, tlast, tuser, 1'b0});
                if (exp_q.size() > 0) begin
                    fd_next = exp_q[0].eof;
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
`ifdef PACKER_SOF_RESYNC_EN
                model_push(in_r, in_g, in_b, in_sof);
`else
                model_push(in_r, in_g, in_b, 1'b0);
`endif
                acc_cnt++;
            end
            fd_exp = fd_next;
            if (frame_done) n_fd++;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        periph_resetn = 1'b0;
        in_valid = 1'b0;
        tready = 1'b0;
`ifdef PACKER_SOF_RESYNC_EN
        in_sof = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        periph_resetn = 1'b1;
        seen.delete();
    endtask

    // Offer pixels until npix are accepted; pattern mode uses r=4p, g=4p+1, b=4p+2
    task automatic run(input int npix, input int vpct, input int rpct, input bit pattern, input int sof_at);
        int start;
        int idx;
        int cyc;
        start = acc_cnt;
        cyc = 0;
        while ((acc_cnt - start) < npix && cyc < npix * 20 + 100) begin
            idx = acc_cnt - start;
            in_valid = ($urandom_range(99) < vpct);
            if (pattern) begin
                in_r = 8'(4 * idx);
                in_g = 8'(4 * idx + 1);
                in_b = 8'(4 * idx + 2);
            end else begin
                in_r = 8'($urandom);
                in_g = 8'($urandom);
                in_b = 8'($urandom);
            end
`ifdef PACKER_SOF_RESYNC_EN
            in_sof = (idx == sof_at);
`endif
            tready = ($urandom_range(99) < rpct);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
`ifdef PACKER_SOF_RESYNC_EN
        in_sof = 1'b0;
`endif
        check("pixels_accepted", 32'(acc_cnt - start), 32'(npix));
    endtask

    task automatic drain();
        int c;
        c = 0;
        tready = 1'b1;
        in_valid = 1'b0;
        while (tvalid && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        @(posedge clk); #1;
        check("drain", 32'(tvalid), 32'd0);
    endtask

    initial begin
        int nu, nl, fd0;
        logic [31:0] held;
        periph_resetn = 1'b0;
        in_valid = 1'b0;
        in_r = '0; in_g = '0; in_b = '0;
        tready = 1'b0;
`ifdef PACKER_SOF_RESYNC_EN
        in_sof = 1'b0;
`endif
        #1;
        check("reset_tvalid_lit", 32'(tvalid), 32'd0);
        do_reset();

        // Four pattern pixels -> three known words
        run(4, 100, 100, 1'b1, -1);
        drain();
        check("w0_lit", seen.size() > 0 ? seen[0].d : 32'hX, 32'h04020100);
        check("w1_lit", seen.size() > 1 ? seen[1].d : 32'hX, 32'h09080605);
        check("w2_lit", seen.size() > 2 ? seen[2].d : 32'hX, 32'h0E0D0C0A);
        check("w0_tuser_lit", seen.size() > 2 ? 32'({seen[0].user, seen[1].user, seen[2].user}) : 32'hX, 32'b100);
        $display("test basic: %0d words", seen.size());

        // Two full frames, always ready
        do_reset();
        fd0 = n_fd;
        run(2 * XP * YS, 100, 100, 1'b0, -1);
        drain();
        nu = 0; nl = 0;
        foreach (seen[i]) begin
            if (seen[i].user) nu++;
            if (seen[i].last) nl++;
        end
        check("frame_words", 32'(seen.size()), 32'(2 * FW));
        check("tuser_count", 32'(nu), 32'd2);
        check("tlast_count", 32'(nl), 32'(2 * YS));
        check("tlast_pos", seen.size() > WPL ? 32'({seen[WPL - 2].last, seen[WPL - 1].last}) : 32'hX, 32'b01);
        check("frame2_tuser", seen.size() > FW ? 32'(seen[FW].user) : 32'hX, 32'd1);
        check("frame_done_count", 32'(n_fd - fd0), 32'd2);
        $display("test full frames: %0d words, %0d tuser, %0d tlast", seen.size(), nu, nl);

        // Backpressure for 5 cycles with a word pending
        do_reset();
        run(2, 100, 100, 1'b0, -1);
        tready = 1'b0;
        in_valid = 1'b1;
        held = tdata;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        check("stall_tdata_stable", tdata, held);
        in_valid = 1'b0;
        run(14, 100, 100, 1'b0, -1);
        drain();
        check("stall_word_total", 32'(seen.size()), 32'd12);
        $display("test stall: %0d words", seen.size());

        // Random valid/ready over two frames
        do_reset();
        fd0 = n_fd;
        run(2 * XP * YS, 50, 50, 1'b0, -1);
        drain();
        check("rand_words", 32'(seen.size()), 32'(2 * FW));
        check("rand_frame_done", 32'(n_fd - fd0), 32'd2);
        $display("test random: %0d words", seen.size());

        // Reset after two pixels of line 3
        do_reset();
        run(3 * XP + 2, 100, 100, 1'b0, -1);
        periph_resetn = 1'b0;
        #1;
        check("midreset_tvalid", 32'(tvalid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        periph_resetn = 1'b1;
        seen.delete();
        run(4, 100, 100, 1'b1, -1);
        drain();
        check("post_reset_w0", seen.size() > 0 ? seen[0].d : 32'hX, 32'h04020100);
        check("post_reset_tuser", seen.size() > 0 ? 32'(seen[0].user) : 32'hX, 32'd1);
        $display("test mid-frame reset: %0d words", seen.size());

`ifdef PACKER_SOF_RESYNC_EN
        // Start-of-frame on pixel 6 restarts the frame
        do_reset();
        run(10, 100, 100, 1'b1, 6);
        drain();
        check("resync_words", 32'(seen.size()), 32'd7);
        check("resync_tuser", seen.size() > 4 ? 32'(seen[4].user) : 32'hX, 32'd1);
        check("resync_r0", seen.size() > 4 ? 32'(seen[4].d[7:0]) : 32'hX, 32'h18);
        check("resync_sof_err", 32'(sof_err), 32'd1);
        $display("test resync: %0d words", seen.size());
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
